// File: rtl/int_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter: handshake states and
// the fixed source index assignment.
package int_arbiter_pkg;

  typedef enum logic [1:0] {
    INTA_IDLE    = 2'd0,
    INTA_REQ     = 2'd1,
    INTA_SERVICE = 2'd2
  } inta_state_e;

  localparam int INT_SRC_TIMER = 0;
  localparam int INT_SRC_EXT   = 1;
  localparam int INT_SRC_SW    = 2;
  localparam int INT_SRC_RSV   = 3;

  localparam int              NUM_SRC_DEF    = 4;
  localparam int              ID_W_DEF       = 2;
  localparam logic [3:0]      MASK_RESET_DEF = 4'b1111;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: reports whether any request is set and the index
// of the lowest set bit (index 0 wins).
module int_prio_enc
  import int_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = ID_W_DEF
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               found_o,
  output logic [ID_W-1:0]    idx_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: masks and prioritises source levels, runs the
// request/ack/done handshake with the CPU and pulses an ack to the winner.
module int_arbiter
  import int_arbiter_pkg::*;
#(
  parameter int                 NUM_SRC    = NUM_SRC_DEF,
  parameter int                 ID_W       = ID_W_DEF,
  parameter logic [NUM_SRC-1:0] MASK_RESET = MASK_RESET_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_SRC-1:0] src_int_i,
  output logic [NUM_SRC-1:0] src_ack_o,
  input  logic               cfg_we_i,
  input  logic [NUM_SRC-1:0] cfg_wdata_i,
  output logic [NUM_SRC-1:0] int_mask_o,
  output logic               cpu_int_o,
  output logic [ID_W-1:0]    cpu_int_id_o,
  input  logic               cpu_ack_i,
  input  logic               cpu_done_i,
  output logic               in_service_o,
  output logic [NUM_SRC-1:0] pending_o
);

  inta_state_e        state_q, state_d;
  logic               cpu_int_q, cpu_int_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_SRC-1:0] ack_q, ack_d;
  logic               in_service_q, in_service_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;

  logic [NUM_SRC-1:0] eligible;
  logic               found;
  logic [ID_W-1:0]    win_id;

  assign eligible = src_int_i & mask_q;

  int_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_prio_enc (
    .req_i   (eligible),
    .found_o (found),
    .idx_o   (win_id)
  );

  // Once in REQ the request is committed: source drop or masking cannot withdraw it.
  always_comb begin
    state_d      = state_q;
    cpu_int_d    = cpu_int_q;
    id_d         = id_q;
    ack_d        = '0;
    in_service_d = in_service_q;
    pending_d    = eligible;
    mask_d       = cfg_we_i ? cfg_wdata_i : mask_q;
    case (state_q)
      INTA_IDLE: begin
        if (found) begin
          id_d      = win_id;
          cpu_int_d = 1'b1;
          state_d   = INTA_REQ;
        end
      end
      INTA_REQ: begin
        if (cpu_ack_i) begin
          cpu_int_d    = 1'b0;
          in_service_d = 1'b1;
          ack_d        = NUM_SRC'(1) << id_q;
          state_d      = INTA_SERVICE;
        end
      end
      INTA_SERVICE: begin
        if (cpu_done_i) begin
          in_service_d = 1'b0;
          state_d      = INTA_IDLE;
        end
      end
      default: begin
        cpu_int_d    = 1'b0;
        in_service_d = 1'b0;
        state_d      = INTA_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= INTA_IDLE;
      cpu_int_q    <= 1'b0;
      id_q         <= '0;
      ack_q        <= '0;
      in_service_q <= 1'b0;
      pending_q    <= '0;
      mask_q       <= MASK_RESET;
    end else begin
      state_q      <= state_d;
      cpu_int_q    <= cpu_int_d;
      id_q         <= id_d;
      ack_q        <= ack_d;
      in_service_q <= in_service_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
    end
  end

  assign src_ack_o    = ack_q;
  assign int_mask_o   = mask_q;
  assign cpu_int_o    = cpu_int_q;
  assign cpu_int_id_o = id_q;
  assign in_service_o = in_service_q;
  assign pending_o    = pending_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: directed vector table, hand-written
// mask and external-source sequences, then randomized traffic against a model.
module tb_int_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] srcInt;
  logic [3:0] srcAck;
  logic       cfgWe;
  logic [3:0] cfgWdata;
  logic [3:0] intMask;
  logic       cpuInt;
  logic [1:0] cpuIntId;
  logic       cpuAck;
  logic       cpuDone;
  logic       inService;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;
  int intRises = 0;
  int ackPulses = 0;
  logic prevInt = 1'b0;

  always #5 clk = ~clk;

  int_arbiter #(
    .NUM_SRC    (4),
    .ID_W       (2),
    .MASK_RESET (4'b1111)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .src_int_i    (srcInt),
    .src_ack_o    (srcAck),
    .cfg_we_i     (cfgWe),
    .cfg_wdata_i  (cfgWdata),
    .int_mask_o   (intMask),
    .cpu_int_o    (cpuInt),
    .cpu_int_id_o (cpuIntId),
    .cpu_ack_i    (cpuAck),
    .cpu_done_i   (cpuDone),
    .in_service_o (inService),
    .pending_o    (pending)
  );

  typedef struct {
    logic       rst;
    logic [3:0] src;
    logic       we;
    logic [3:0] wd;
    logic       ack;
    logic       done;
    logic       eInt;
    logic [1:0] eId;
    logic [3:0] eAck;
    logic       eSvc;
    logic [3:0] ePend;
    logic [3:0] eMask;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model state: "requesting" and "servicing" flags plus outputs.
  logic       mReq, mSvc;
  logic [1:0] mId;
  logic [3:0] mAck, mPend, mMask;

  task automatic tick();
    @(posedge clk);
    #1;
    if (cpuInt && !prevInt) intRises++;
    if (srcAck != 4'b0) ackPulses++;
    prevInt = cpuInt;
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] s, input logic we,
                               input logic [3:0] wd, input logic a, input logic d);
    reset    = r;
    srcInt   = s;
    cfgWe    = we;
    cfgWdata = wd;
    cpuAck   = a;
    cpuDone  = d;
  endtask

  task automatic checkOne(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag, input logic eInt, input logic [1:0] eId,
                             input logic [3:0] eAck, input logic eSvc,
                             input logic [3:0] ePend, input logic [3:0] eMask);
    checkOne({tag, ".cpu_int"},    {3'b0, cpuInt},    {3'b0, eInt});
    checkOne({tag, ".cpu_int_id"}, {2'b0, cpuIntId},  {2'b0, eId});
    checkOne({tag, ".src_ack"},    srcAck,            eAck);
    checkOne({tag, ".in_service"}, {3'b0, inService}, {3'b0, eSvc});
    checkOne({tag, ".pending"},    pending,           ePend);
    checkOne({tag, ".int_mask"},   intMask,           eMask);
  endtask

  function automatic logic [1:0] lowestIdx(input logic [3:0] v);
    logic [3:0] iso;
    iso = v & (~v + 4'd1);
    case (iso)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic modelStep(input logic r, input logic [3:0] s, input logic we,
                           input logic [3:0] wd, input logic a, input logic d);
    logic [3:0] elig;
    if (r) begin
      mReq = 1'b0; mSvc = 1'b0; mId = 2'd0;
      mAck = 4'b0; mPend = 4'b0; mMask = 4'hF;
    end else begin
      elig  = s & mMask;
      mPend = elig;
      mAck  = 4'b0;
      if (!mReq && !mSvc) begin
        if (elig != 4'b0) begin
          mReq = 1'b1;
          mId  = lowestIdx(elig);
        end
      end else if (mReq) begin
        if (a) begin
          mReq = 1'b0;
          mSvc = 1'b1;
          mAck = 4'b0001 << mId;
        end
      end else if (d) begin
        mSvc = 1'b0;
      end
      if (we) mMask = wd;
    end
  endtask

  initial begin
    vec_t v;
    logic r, we, a, d;
    logic [3:0] s, wd;

    applyStimulus(1'b1, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0);

    // rst src we wd ack done | int id ack svc pend mask
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'hF});
    tbl.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b0010, 4'hF});
    tbl.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b0010, 4'hF});
    tbl.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 4'hF});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 4'hF});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, 4'hF});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b0000, 4'hF});
    tbl.push_back('{1'b0, 4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b1010, 4'hF});
    tbl.push_back('{1'b0, 4'b1010, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b1, 4'b1010, 4'hF});
    tbl.push_back('{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1, 4'b1000, 4'hF});
    tbl.push_back('{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0, 4'b1000, 4'hF});
    tbl.push_back('{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b0, 4'b1000, 4'hF});
    tbl.push_back('{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 4'hF});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0, 4'b0000, 4'hF});
    // Masking while in REQ, then cfg_we together with cpu_ack.
    tbl.push_back('{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b0010, 4'hF});
    tbl.push_back('{1'b0, 4'b0010, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b0, 4'b0010, 4'h0});
    tbl.push_back('{1'b0, 4'b0010, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0010, 1'b1, 4'b0000, 4'hF});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 4'hF});
    // Reset in SERVICE, reset coinciding with cpu_ack in REQ.
    tbl.push_back('{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'hF});
    tbl.push_back('{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0100, 4'hF});
    tbl.push_back('{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'hF});
    // cpu_done in REQ ignored, ack+done treated as ack, ack in SERVICE ignored.
    tbl.push_back('{1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0100, 4'hF});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 1'b0, 4'b0000, 4'hF});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b1, 4'b0000, 4'hF});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 1'b1, 4'b0000, 4'hF});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000, 4'hF});
    tbl.push_back('{1'b0, 4'b0001, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 4'b0001, 4'b0101});
    tbl.push_back('{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 4'b0101});
    tbl.push_back('{1'b1, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'hF});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 4'hF});

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      applyStimulus(v.rst, v.src, v.we, v.wd, v.ack, v.done);
      tick();
      checkOutput($sformatf("vec%0d", i), v.eInt, v.eId, v.eAck, v.eSvc, v.ePend, v.eMask);
    end

    // Masked source stays silent until unmasked; unmask write uses old mask that cycle.
    applyStimulus(1'b0, 4'b0000, 1'b1, 4'b1101, 1'b0, 1'b0);
    tick();
    checkOutput("maskWr", 1'b0, 2'd0, 4'b0, 1'b0, 4'b0, 4'b1101);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
      tick();
      checkOutput($sformatf("masked%0d", i), 1'b0, 2'd0, 4'b0, 1'b0, 4'b0, 4'b1101);
    end
    applyStimulus(1'b0, 4'b0010, 1'b1, 4'b1111, 1'b0, 1'b0);
    tick();
    checkOutput("unmaskWr", 1'b0, 2'd0, 4'b0, 1'b0, 4'b0, 4'hF);
    applyStimulus(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("unmaskGrant", 1'b1, 2'd1, 4'b0, 1'b0, 4'b0010, 4'hF);
    applyStimulus(1'b0, 4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("unmaskAck", 1'b0, 2'd1, 4'b0010, 1'b1, 4'b0010, 4'hF);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    tick();

    // External source on bit 1; CPU acks 3 cycles after cpu_int, done 5 after ack.
    intRises  = 0;
    ackPulses = 0;
    for (int n = 0; n < 20; n++) begin
      srcInt = 4'b0010;
      for (int k = 0; k < 10 && !cpuInt; k++) tick();
      checkOne("extGrant", {3'b0, cpuInt}, 4'b0001);
      tick();
      tick();
      cpuAck = 1'b1;
      tick();
      cpuAck = 1'b0;
      checkOne("extAck", srcAck, 4'b0010);
      srcInt = 4'b0000;
      for (int k = 0; k < 4; k++) tick();
      cpuDone = 1'b1;
      tick();
      cpuDone = 1'b0;
      tick();
    end
    tick();
    checkOne("extIntCount", 4'(intRises), 4'(20));
    checkOne("extIntCountHi", 4'(intRises >> 4), 4'(20 >> 4));
    checkOne("extAckCount", 4'(ackPulses), 4'(20));
    checkOne("extAckCountHi", 4'(ackPulses >> 4), 4'(20 >> 4));

    // Randomized traffic against the model, starting from a reset.
    modelStep(1'b1, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b0, 1'b0, 4'b0, 1'b0, 1'b0);
    tick();
    checkOutput("rndReset", mReq, mId, mAck, mSvc, mPend, mMask);
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 31) == 0);
      s  = 4'($urandom_range(0, 15));
      we = ($urandom_range(0, 7) == 0);
      wd = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 2) == 0);
      applyStimulus(r, s, we, wd, a, d);
      modelStep(r, s, we, wd, a, d);
      tick();
      checkOutput($sformatf("rnd%0d", i), mReq, mId, mAck, mSvc, mPend, mMask);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_arbiter.md
Name: int_arbiter

Overview:
- Interrupt controller between the interrupt sources (timer, external_int_gen, software) and the pipeline's exception logic.
- Masks and arbitrates level requests by fixed priority and presents one request plus source ID to the CPU.
- Runs the request/ack/done handshake with the CPU.
- Returns a one-cycle acknowledge pulse to the winning source so the source can drop its level.

Parameters:
- NUM_SRC, 4, number of interrupt source lines; index 0 is highest priority.
- ID_W, 2, width of the source ID; must satisfy 2**ID_W >= NUM_SRC.
- MASK_RESET, 4'b1111, enable-mask value after reset (bit i = 1 means source i is enabled).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- src_int  input  NUM_SRC  level interrupt requests; each is held until its src_ack.
- src_ack  output  NUM_SRC  one-hot, one-cycle acknowledge pulse to the serviced source.
- cfg_we  input  1  mask write strobe.
- cfg_wdata  input  NUM_SRC  new enable mask.
- int_mask  output  NUM_SRC  current enable mask.
- cpu_int  output  1  interrupt request to the CPU.
- cpu_int_id  output  ID_W  ID of the requesting source; valid while cpu_int or in_service is high.
- cpu_ack  input  1  CPU has taken the interrupt (trap entered).
- cpu_done  input  1  CPU has left the handler (eret retired).
- in_service  output  1  a handler is active.
- pending  output  NUM_SRC  src_int & int_mask, registered.

Behaviour:
- Reset (synchronous, checked every cycle and overriding everything):
  - state=IDLE; cpu_int=0; cpu_int_id=0; src_ack=0; in_service=0; pending=0; int_mask=MASK_RESET.
  - Reset mid-handshake abandons the transaction; no src_ack is issued.
- State machine, 3 states:
  - IDLE: if (src_int & int_mask) != 0, latch the lowest set index into cpu_int_id, set cpu_int=1, go to REQ. cpu_int rises exactly 1 cycle after src_int is sampled high. Otherwise stay in IDLE.
  - REQ: cpu_int=1 and cpu_int_id held stable. On cpu_ack: next cycle cpu_int=0, in_service=1, src_ack[cpu_int_id]=1 for exactly 1 cycle, go to SERVICE.
    - The request is committed once in REQ. Deassertion of src_int or masking the source does not withdraw it.
    - cpu_done in REQ is ignored.
  - SERVICE: no arbitration. On cpu_done: in_service=0, go to IDLE. cpu_ack in SERVICE is ignored (no nesting).
- After returning to IDLE, arbitration starts the following cycle.
  - A source still high, or re-raised, is granted again.
  - Minimum cpu_done to next cpu_int rising edge: 2 cycles.
- Mask writes:
  - cfg_we updates int_mask at the clock edge, in any state.
  - Arbitration in the same cycle uses the old mask.
- pending is updated every cycle from the current src_int & int_mask.
- src_ack is always zero or one-hot. It is never asserted outside the cycle after cpu_ack in REQ.
- Source indices ≥ NUM_SRC are never issued. cpu_int_id is zero-extended to ID_W.
- Simultaneous events:
  - cpu_ack and cpu_done in the same REQ cycle: treat as cpu_ack only.
  - cfg_we and cpu_ack in the same cycle: both take effect.

Decomposition:
- def.v gets:
  - state encodings INTA_IDLE=2'd0, INTA_REQ=2'd1, INTA_SERVICE=2'd2;
  - source indices INT_SRC_TIMER=0, INT_SRC_EXT=1, INT_SRC_SW=2, INT_SRC_RSV=3.
- Sub-module int_prio_enc: combinational fixed-priority encoder, NUM_SRC-bit vector in, outputs found and ID_W-bit index.
- int_arbiter holds the FSM, mask register and ack pulse generation.

Test Plan:
1. Reset, then src_int=4'b0010 at cycle 5 → cpu_int=1 at cycle 6 with cpu_int_id=1. cpu_ack at cycle 8 → src_ack=4'b0010 for cycle 9 only, in_service=1 from cycle 9. cpu_done at cycle 12 → in_service=0 at cycle 13.
2. src_int=4'b1010 in IDLE → cpu_int_id=1. After done, with bit1 cleared and bit3 held → next grant cpu_int_id=3.
3. Mask test: cfg_we with cfg_wdata=4'b1101, then src_int=4'b0010 → cpu_int stays 0 and pending=0. Unmask → cpu_int rises 1 cycle after the mask write takes effect.
4. Masking in REQ: in REQ with id=1, write cfg_wdata=4'b0000 → cpu_int stays 1. cpu_ack → src_ack[1] still pulses.
5. Reset during SERVICE: assert reset 1 cycle → next cycle all outputs at reset values, int_mask=4'b1111, no src_ack pulse.
6. Loop with external_int_gen (EXT_INT_LIMIT=20) on bit 1 and the CPU acking after 3 cycles and signalling done after 5 → every external_int assertion produces exactly one cpu_int and one src_ack. external_int falls the cycle after src_ack.
